aes_key_expand_128: RTL and testbench

- Iterative AES-128 key schedule (FIPS-197 §5.2).
- Accepts a 128-bit cipher key and emits round keys 0..NUM_ROUNDS, one per accepted output transfer, over a valid/ready stream.
- Sits beside the round datapath and feeds its AddRoundKey stage.
- Contains the byte-substitution table lookups for SubWord via four S-box instances.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_sub_word.sv | 47 ++++
 rtl/aes_key_expand_128.sv | 95 +++++++++
 tb/tb_aes_key_expand_128.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, schedule constants and
// the GF(2^8) doubling used to step the round constant.
package aes_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  localparam int         AES_NR_128 = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    logic [7:0] red;
    if (r[7]) begin
      red = XTIME_POLY;
    end else begin
      red = 8'h00;
    end
    return {r[6:0], 1'b0} ^ red;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// AES SubWord: four independent byte substitutions. Byte lane i of the input
// maps to byte lane i of the output. Also contains the single-byte S-box.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base_s;

  assign base_s   = 11'd2047 - {in_byte, 3'b000};
  assign out_byte = SBOX_TABLE[base_s -: 8];

endmodule

module aes_sub_word (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (word_in[8*i +: 8]),
      .out_byte (word_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule. A key is accepted in IDLE and round keys
// 0..NUM_ROUNDS are then streamed out, one per accepted transfer.
module aes_key_expand_128
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR_128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t       state_r;
  logic [7:0]   rcon_r;
  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  logic [31:0]  t_s;
  logic [31:0]  n0_s;
  logic [31:0]  n1_s;
  logic [31:0]  n2_s;
  logic [31:0]  n3_s;
  logic [127:0] next_rk_s;

  // RotWord of w3 feeds the S-box lanes
  assign rot_s = {rk_out[23:0], rk_out[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_s),
    .word_out (sub_s)
  );

  // Next round key: round-constant mix followed by the word XOR chain
  always_comb begin
    t_s       = sub_s ^ {rcon_r, 24'h000000};
    n0_s      = rk_out[127:96] ^ t_s;
    n1_s      = rk_out[95:64]  ^ n0_s;
    n2_s      = rk_out[63:32]  ^ n1_s;
    n3_s      = rk_out[31:0]   ^ n2_s;
    next_rk_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Handshake flags decoded from registered state only
  assign key_ready = (state_r == IDLE);
  assign rk_last   = rk_valid && (rk_idx == LAST_IDX);

  // Controller and round-key registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      rk_out   <= 128'd0;
      rk_idx   <= 4'd0;
      rk_valid <= 1'b0;
      rcon_r   <= RCON_INIT;
    end else begin
      case (state_r)
        IDLE: begin
          if (key_valid) begin
            rk_out   <= key_in;
            rk_idx   <= 4'd0;
            rcon_r   <= RCON_INIT;
            rk_valid <= 1'b1;
            state_r  <= OUT;
          end
        end
        OUT: begin
          // A stalled key (valid without ready) simply holds
          if (rk_valid && rk_ready) begin
            if (rk_idx == LAST_IDX) begin
              rk_valid <= 1'b0;
              state_r  <= IDLE;
            end else begin
              rk_out <= next_rk_s;
              rk_idx <= rk_idx + 4'd1;
              rcon_r <= xtime(rcon_r);
            end
          end
        end
        default: begin
          rk_valid <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128. Expected round keys come from a
// GF(2^8) model built from field arithmetic (inverse plus affine map).
module tb_aes_key_expand_128;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [NR+1];
  logic [127:0] seen_rk [NR+1];

  aes_key_expand_128 #(.NUM_ROUNDS(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(x));
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 key expansion over 44 words
  task automatic compute_exp(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start_key(input logic [127:0] key);
    int n;
    n = 0;
    while (!key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("key_ready_wait", 128'(key_ready), 128'(1));
    key_in = key;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Consume round keys with the given ready duty; stop at index stop_e
  task automatic drain(input int pct, input bit hold, input int stop_e, output int cycles);
    int e;
    bit rdy;
    e = 0;
    cycles = 0;
    while (e <= NR && e != stop_e && cycles < 200) begin
      check("rk_valid", 128'(rk_valid), 128'(1));
      check("rk_idx", 128'(rk_idx), 128'(e));
      check("rk_out", rk_out, exp_rk[e]);
      check("rk_last", 128'(rk_last), 128'(e == NR));
      if (hold) check("key_ready_busy", 128'(key_ready), 128'(0));
      rdy = (int'($urandom_range(99)) < pct);
      rk_ready = rdy;
      if (rdy) seen_rk[e] = rk_out;
      @(negedge clk);
      cycles++;
      if (rdy) e++;
    end
    rk_ready = 1'b0;
    check("drain_progress", 128'(e), 128'((stop_e <= NR) ? stop_e : NR + 1));
  endtask

  task automatic check_done();
    check("done_rk_valid", 128'(rk_valid), 128'(0));
    check("done_rk_last", 128'(rk_last), 128'(0));
    check("done_key_ready", 128'(key_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] key_a;
    logic [127:0] key_b;
    int cyc;

    rst = 1'b1;
    key_in = 128'd0;
    key_valid = 1'b0;
    rk_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("rst_rk_valid", 128'(rk_valid), 128'(0));
    check("rst_rk_idx", 128'(rk_idx), 128'(0));
    check("rst_rk_out", rk_out, 128'd0);
    check("rst_rk_last", 128'(rk_last), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_key_ready", 128'(key_ready), 128'(1));

    // FIPS-197 A.1 key with continuous ready
    key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    compute_exp(key_a);
    start_key(key_a);
    drain(100, 1'b0, 99, cyc);
    check("cont_cycles", 128'(cyc), 128'(NR + 1));
    check_done();
    check("a1_idx0", seen_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("a1_idx1", seen_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_idx2", seen_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("a1_idx10", seen_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Same key under random backpressure
    start_key(key_a);
    drain(30, 1'b0, 99, cyc);
    check_done();
    check("bp_idx10", seen_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key exercises the 1b/36 round constants
    compute_exp(128'd0);
    start_key(128'd0);
    drain(100, 1'b0, 99, cyc);
    check_done();
    check("zero_idx1", seen_rk[1], 128'h62636363626363636263636362636363);
    check("zero_idx10", seen_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // key_valid held during OUT is ignored, then accepted back-to-back
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    compute_exp(key_a);
    start_key(key_a);
    key_in = key_b;
    key_valid = 1'b1;
    drain(50, 1'b1, 99, cyc);
    check("b2b_key_ready", 128'(key_ready), 128'(1));
    compute_exp(key_b);
    @(negedge clk);
    key_valid = 1'b0;
    drain(100, 1'b0, 99, cyc);
    check_done();

    // Asynchronous reset after idx4, then restart from round 0
    key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    compute_exp(key_a);
    start_key(key_a);
    drain(100, 1'b0, 5, cyc);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
    check("mid_rst_rk_idx", 128'(rk_idx), 128'(0));
    check("mid_rst_rk_out", rk_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_key_ready", 128'(key_ready), 128'(1));
    key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
    compute_exp(key_b);
    start_key(key_b);
    drain(60, 1'b0, 99, cyc);
    check_done();

    // A few more random keys at random duty
    for (int n = 0; n < 4; n++) begin
      key_a = {$urandom(), $urandom(), $urandom(), $urandom()};
      compute_exp(key_a);
      start_key(key_a);
      drain(20 + 20 * n, 1'b0, 99, cyc);
      check_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
